// File: rtl/zl_fifo_sc_pkg.sv
// Types shared by the zl_fifo_sc top and its storage.
package zl_fifo_sc_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/zl_fifo_defs.vh
// Shared definitions for the zl_fifo family: elaboration-time parameter checks.
`ifndef ZL_FIFO_DEFS_VH
`define ZL_FIFO_DEFS_VH

// Expands to a generate-if that stops elaboration on an illegal depth or threshold.
`define ZL_FIFO_CHECK_PARAMS(AW, DEPTH, AF, AE) \
    if ((AW) < 1 || (AF) < 1 || (AF) > (DEPTH) || (AE) < 0 || (AE) > (DEPTH) - 1) begin : g_param_err \
        $error("zl_fifo: illegal AddrWidth or threshold parameters"); \
    end

`endif

// File: rtl/zl_fifo_mem.sv
// Depth x Width register array: one synchronous write port, one combinational read port.
module zl_fifo_mem #(
    parameter int Width     = 8,
    parameter int AddrWidth = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [Width-1:0]     wdata,
    input  logic [AddrWidth-1:0] raddr,
    output logic [Width-1:0]     rdata
);
    localparam int Depth = 1 << AddrWidth;

    logic [Depth-1:0][Width-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  mem_q        <= '0;
        else if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/zl_fifo_sc.sv
// Parametrised single-clock req/ack FIFO with occupancy, almost flags and flush.
// Optional high-water mark tracker enabled by defining ZL_FIFO_SC_HWM_EN.
`include "zl_fifo_defs.vh"

module zl_fifo_sc
    import zl_fifo_sc_pkg::*;
#(
    parameter int Width          = 8,
    parameter int AddrWidth      = 4,
    parameter int AlmostFullThr  = 12,
    parameter int AlmostEmptyThr = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 data_in_req,
    output logic                 data_in_ack,
    input  logic [Width-1:0]     data_in,
    output logic                 data_out_req,
    input  logic                 data_out_ack,
    output logic [Width-1:0]     data_out,
    output logic [AddrWidth:0]   used,
    output logic                 almost_full,
    output logic                 almost_empty
`ifdef ZL_FIFO_SC_HWM_EN
    ,
    input  logic                 hwm_clr,
    output logic [AddrWidth:0]   hwm
`endif
);
    localparam int Depth = 1 << AddrWidth;
    localparam logic [AddrWidth:0] DepthW = (AddrWidth + 1)'(Depth);
    localparam logic [AddrWidth:0] AfThr  = (AddrWidth + 1)'(AlmostFullThr);
    localparam logic [AddrWidth:0] AeThr  = (AddrWidth + 1)'(AlmostEmptyThr);
    localparam logic [AddrWidth:0] One    = (AddrWidth + 1)'(1);

    `ZL_FIFO_CHECK_PARAMS(AddrWidth, Depth, AlmostFullThr, AlmostEmptyThr)

    logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrWidth:0]   used_q, used_d;
    logic                 full, empty, push, pop;
    fifo_op_e             op;

    // Full/empty come from the count only; pointers alone are ambiguous when equal.
    assign full  = (used_q == DepthW);
    assign empty = (used_q == '0);
    assign push  = data_in_req  && !full  && !flush;
    assign pop   = data_out_ack && !empty && !flush;
    assign op    = fifo_op(push, pop);

    always_comb begin
        used_d = used_q;
        case (op)
            OP_PUSH: used_d = used_q + One;
            OP_POP:  used_d = used_q - One;
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            used_q <= used_d;
        end
    end

    zl_fifo_mem #(
        .Width     (Width),
        .AddrWidth (AddrWidth)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

    assign data_in_ack  = push;
    assign data_out_req = !empty;
    assign used         = used_q;
    assign almost_full  = (used_q >= AfThr);
    assign almost_empty = (used_q <= AeThr);

`ifdef ZL_FIFO_SC_HWM_EN
    logic [AddrWidth:0] hwm_q;

    // Occupancy only rises on push-only cycles, so those are the only candidates for a new peak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                hwm_q <= '0;
        else if (hwm_clr)                          hwm_q <= used_q;
        else if (op == OP_PUSH && used_d > hwm_q)  hwm_q <= used_d;
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_zl_fifo_sc.sv
// Directed + randomized bench for zl_fifo_sc against a queue-based reference model.
module tb_zl_fifo_sc;
    localparam int W     = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;
    localparam int AET   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          data_in_req = 1'b0;
    logic          data_in_ack;
    logic [W-1:0]  data_in = '0;
    logic          data_out_req;
    logic          data_out_ack = 1'b0;
    logic [W-1:0]  data_out;
    logic [AW:0]   used;
    logic          almost_full;
    logic          almost_empty;
`ifdef ZL_FIFO_SC_HWM_EN
    logic          hwm_clr = 1'b0;
    logic [AW:0]   hwm;
`endif

    int checks = 0;
    int failures = 0;

    logic [W-1:0] mq[$];
    int           m_hwm = 0;

    always #5 clk = ~clk;

    zl_fifo_sc #(
        .Width(W), .AddrWidth(AW), .AlmostFullThr(AFT), .AlmostEmptyThr(AET)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .data_in_req  (data_in_req),
        .data_in_ack  (data_in_ack),
        .data_in      (data_in),
        .data_out_req (data_out_req),
        .data_out_ack (data_out_ack),
        .data_out     (data_out),
        .used         (used),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef ZL_FIFO_SC_HWM_EN
        ,
        .hwm_clr      (hwm_clr),
        .hwm          (hwm)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle at the falling edge, checks everything against the model, then advances it.
    task automatic cycle(input logic req, input logic [W-1:0] din, input logic oack,
                         input logic fl, input logic clr);
        int  sz;
        bit  e_push, e_pop;
        @(negedge clk);
        data_in_req  = req;
        data_in      = din;
        data_out_ack = oack;
        flush        = fl;
`ifdef ZL_FIFO_SC_HWM_EN
        hwm_clr      = clr;
`endif
        #1;
        sz     = mq.size();
        e_push = req && (sz < DEPTH) && !fl;
        e_pop  = oack && (sz > 0) && !fl;
        chk("data_in_ack", 32'(data_in_ack), 32'(e_push));
        chk("data_out_req", 32'(data_out_req), 32'(sz != 0));
        chk("used", 32'(used), 32'(sz));
        chk("almost_full", 32'(almost_full), 32'(sz >= AFT));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= AET));
        if (sz != 0) chk("data_out", 32'(data_out), 32'(mq[0]));
`ifdef ZL_FIFO_SC_HWM_EN
        chk("hwm", 32'(hwm), 32'(m_hwm));
`endif
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (e_pop)  void'(mq.pop_front());
            if (e_push) mq.push_back(din);
        end
        if (clr) m_hwm = sz;
        else if (mq.size() > m_hwm) m_hwm = mq.size();
`ifndef ZL_FIFO_SC_HWM_EN
        if (clr) m_hwm = 0;
`endif
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_used", 32'(used), 0);
        chk("rst_out_req", 32'(data_out_req), 0);
        chk("rst_in_ack", 32'(data_in_ack), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_almost_full", 32'(almost_full), 0);
        chk("rst_almost_empty", 32'(almost_empty), 1);
`ifdef ZL_FIFO_SC_HWM_EN
        chk("rst_hwm", 32'(hwm), 0);
`endif
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Fill 0x01..0x10, then a 17th request that must be refused
        for (int i = 1; i <= 16; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        #1;
        chk("fill_used16", 32'(used), 16);
        chk("fill_ack17", 32'(data_in_ack), 0);
        chk("fill_af", 32'(almost_full), 1);

        // Drain in order
        for (int i = 1; i <= 16; i++) begin
            #1;
            chk("drain_order", 32'(data_out), 32'(i));
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        #1;
        chk("drain_out_req", 32'(data_out_req), 0);
        chk("drain_ae", 32'(almost_empty), 1);

        // Latency: nothing visible in the push cycle, word visible the next
        cycle(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lat_req_n1", 32'(data_out_req), 1);
        chk("lat_data_n1", 32'(data_out), 32'h A5);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Wrap with used held at 3 via simultaneous push/pop
        for (int i = 0; i < 3; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, W'($urandom), 1'b1, 1'b0, 1'b0);
        #1;
        chk("wrap_used3", 32'(used), 3);

        // Full with pop: push refused at full, accepted the cycle after
        while (mq.size() < DEPTH) cycle(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fullpop_used15", 32'(used), 15);
        cycle(1'b1, 8'h78, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fullpop_hold15", 32'(used), 15);

        // Flush with used = 7 and both handshakes asserted
        while (mq.size() > 7) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        #1;
        chk("flush_used0", 32'(used), 0);
        chk("flush_out_req", 32'(data_out_req), 0);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush_first_3c", 32'(data_out), 32'h3C);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic, occasional flush
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 40) == 0), 1'b0);
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 2) == 0), W'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'b0, 1'b0);

`ifdef ZL_FIFO_SC_HWM_EN
        // HWM: fresh reset, push 9, pop 4, clear to current occupancy
        @(negedge clk);
        rst_n = 1'b0;
        data_in_req = 1'b0; data_out_ack = 1'b0; flush = 1'b0; hwm_clr = 1'b0;
        mq.delete(); m_hwm = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) cycle(1'b1, W'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("hwm_peak9", 32'(hwm), 9);
        cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        #1;
        chk("hwm_clr5", 32'(hwm), 5);
        chk("hwm_clr_used6", 32'(used), 6);
`endif

        // Asynchronous reset mid-cycle with words in flight
        cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        data_in_req = 1'b1; data_out_ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_used0", 32'(used), 0);
        chk("async_out_req0", 32'(data_out_req), 0);
        chk("async_data_out0", 32'(data_out), 0);
`ifdef ZL_FIFO_SC_HWM_EN
        chk("async_hwm0", 32'(hwm), 0);
`endif
        data_in_req = 1'b0; data_out_ack = 1'b0;
        mq.delete(); m_hwm = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/zl_fifo_sc.md
Name: zl_fifo_sc

Overview:
- Parametrised single-clock FIFO; successor to the fixed depth-2 FIFO.
- Configurable width and power-of-two depth.
- Adds occupancy count, almost-full/almost-empty flags and synchronous flush.
- Sits between req/ack streaming stages where more than two entries of elasticity are needed.

Parameters:
- Width, 8, data word width in bits (>=1).
- AddrWidth, 4, log2 of depth; Depth = 2**AddrWidth entries (AddrWidth >= 1).
- AlmostFullThr, 12, almost_full asserts when used >= AlmostFullThr (1..Depth).
- AlmostEmptyThr, 2, almost_empty asserts when used <= AlmostEmptyThr (0..Depth-1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous clear of FIFO contents.
- data_in_req  in  1  producer has a word on data_in.
- data_in_ack  out  1  word accepted this cycle.
- data_in  in  Width  write data.
- data_out_req  out  1  FIFO non-empty; data_out valid.
- data_out_ack  in  1  consumer takes data_out this cycle.
- data_out  out  Width  head-of-FIFO word.
- used  out  AddrWidth+1  current occupancy, 0..Depth.
- almost_full  out  1  used >= AlmostFullThr.
- almost_empty  out  1  used <= AlmostEmptyThr.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: wr_ptr = rd_ptr = 0, used = 0, storage = 0, data_out_req = 0, data_in_ack = 0, data_out = 0, almost_full = 0, almost_empty = 1.
- Push:
  - data_in_ack = data_in_req && !full && !flush (combinational).
  - On ack, mem[wr_ptr] <= data_in; wr_ptr increments modulo Depth.
- Pop:
  - Occurs when data_out_ack && !empty && !flush; rd_ptr increments modulo Depth.
  - data_out_ack while empty is ignored: no pointer or count change.
- Output path:
  - data_out = mem[rd_ptr], combinational from registered storage.
  - data_out_req = (used != 0).
- Latency: word pushed in cycle N raises data_out_req and appears on data_out in cycle N+1. There is no same-cycle bypass.
- Count update:
  - push only: used + 1.
  - pop only: used - 1.
  - push and pop together: used unchanged, both pointers advance.
  - neither: unchanged.
- Full (used == Depth): data_in_ack = 0 even if a pop occurs the same cycle. No full-throughput pass-through at full, same rule as the depth-2 block.
- Empty: a push and an ack in the same cycle perform the push only.
- Pointer wrap: pointers are AddrWidth bits and wrap naturally. Full/empty are decided solely by used, never by pointer compare.
- Flush:
  - Next cycle: pointers = 0, used = 0.
  - Storage contents are left unchanged.
  - Flush has priority over simultaneous push/pop; both are suppressed and data_in_ack = 0 during flush.
- Flags: almost_full and almost_empty are combinational from registered used, so they update in the cycle after the causing push/pop.
- Reset mid-operation: all state returns immediately to reset values; any in-flight handshake is discarded.

Optional Feature:
- Macro: ZL_FIFO_SC_HWM_EN.
- When defined:
  - Adds output hwm [AddrWidth:0], the high-water mark = max used since reset or last clear.
  - Adds input hwm_clr [1].
  - hwm updates to used+1 on a push-only cycle when that exceeds hwm.
  - hwm_clr sets hwm to the current used next cycle; hwm_clr wins over a same-cycle update.
  - Reset value of hwm is 0. flush does not clear hwm.
- When undefined: no ports, no registers; behaviour otherwise identical.

Decomposition:
- Shared include zl_fifo_defs.vh: a parameter-check macro for threshold range and AddrWidth >= 1.
- Sub-module zl_fifo_mem: Depth x Width register array with one write port and one combinational read port, async-reset to zero.
- Top zl_fifo_sc holds pointers, count, flags, flush and the HWM logic.

Test Plan:
- Fill/drain: defaults; push 0x01..0x10 with data_out_ack = 0. Then:
  - used reaches 16, data_in_ack drops on the 17th request, almost_full is set from used = 12.
  - Drain returns 0x01..0x10 in order, then data_out_req = 0 and almost_empty = 1.
- Latency: push 0xA5 into an empty FIFO in cycle N; data_out_req = 1 and data_out = 0xA5 in cycle N+1, not in N.
- Wrap plus simultaneous push/pop: hold used = 3 while streaming 40 words with push and pop every cycle. Then:
  - used stays 3 and pointers wrap at least twice.
  - Output sequence equals input delayed by 3.
- Full with pop: used = 16, data_in_req = 1, data_out_ack = 1. Then:
  - data_in_ack = 0 and used becomes 15.
  - The next cycle push is accepted and used stays 15 with continued pop.
- Flush: used = 7, assert flush with data_in_req = data_out_ack = 1. Then:
  - data_in_ack = 0 and next cycle used = 0, data_out_req = 0.
  - A subsequent push of 0x3C is read back first.
- Async reset with HWM: build ZL_FIFO_SC_HWM_EN; push 9 and pop 4, so hwm = 9. Then:
  - hwm_clr sets hwm to 5.
  - rst_n pulse low mid-cycle immediately zeroes used, hwm and data_out_req.
